// File: rtl/digit_pulse_gen_if.sv
// Control and timing bus of the digit pulse generator.
// master drives run/stop/step and observes timing; slave is the generator itself.
interface digit_pulse_gen_if #(
    parameter int DIGITS  = 36,
    parameter int MINOR_W = 4
);
    logic               start;
    logic               stop;
    logic               step;
    logic [DIGITS-1:0]  d;
    logic               d0;
    logic               d1;
    logic               d18;
    logic               d35;
    logic [5:0]         digit;
    logic [MINOR_W-1:0] minor;
    logic               major_d0;
    logic               running;

    modport master (
        output start, stop, step,
        input  d, d0, d1, d18, d35, digit, minor, major_d0, running
    );

    modport slave (
        input  start, stop, step,
        output d, d0, d1, d18, d35, digit, minor, major_d0, running
    );
endinterface

// File: rtl/digit_pulse_gen.sv
// Master digit-time generator: one-hot d0..d35 per minor cycle, minor/major indices,
// and run/stop/single-step control that only ever halts on a minor-cycle boundary.
module digit_pulse_gen #(
    parameter int DIGITS  = 36,
    parameter int MINORS  = 16,
    parameter int MINOR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    digit_pulse_gen_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, STEP} state_t;

    localparam logic [5:0]         LAST_DIGIT = 6'(DIGITS - 1);
    localparam logic [MINOR_W-1:0] LAST_MINOR = MINOR_W'(MINORS - 1);

    state_t             state_q, state_d;
    logic [5:0]         digit_q, digit_d;
    logic [MINOR_W-1:0] minor_q, minor_d;
    logic               stop_lat_q, stop_lat_d;
    logic [DIGITS-1:0]  d_q, d_d;
    logic               major_q, major_d;

    always_comb begin
        state_d    = state_q;
        digit_d    = digit_q;
        minor_d    = minor_q;
        stop_lat_d = stop_lat_q;

        case (state_q)
            IDLE: begin
                digit_d = '0;
                // stop overrides both start and step; start beats step
                if (!bus.stop) begin
                    if (bus.start)     state_d = RUN;
                    else if (bus.step) state_d = STEP;
                end
            end
            RUN, STEP: begin
                if (digit_q == LAST_DIGIT) begin
                    digit_d = '0;
                    minor_d = (minor_q == LAST_MINOR) ? '0 : minor_q + MINOR_W'(1);
                    if (state_q == STEP || stop_lat_q || bus.stop) begin
                        state_d    = IDLE;
                        stop_lat_d = 1'b0;
                    end
                end else begin
                    digit_d = digit_q + 6'd1;
                    if (state_q == RUN && bus.stop) stop_lat_d = 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                digit_d    = '0;
                stop_lat_d = 1'b0;
            end
        endcase

        // Outputs are pre-decoded from the next state so they leave straight from flops
        d_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d_d[i] = (state_d != IDLE) && (digit_d == 6'(i));
        end
        major_d = (state_d != IDLE) && (digit_d == '0) && (minor_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            digit_q    <= '0;
            minor_q    <= '0;
            stop_lat_q <= 1'b0;
            d_q        <= '0;
            major_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            digit_q    <= digit_d;
            minor_q    <= minor_d;
            stop_lat_q <= stop_lat_d;
            d_q        <= d_d;
            major_q    <= major_d;
        end
    end

    assign bus.d        = d_q;
    assign bus.d0       = d_q[0];
    assign bus.d1       = d_q[1];
    assign bus.d18      = d_q[18];
    assign bus.d35      = d_q[35];
    assign bus.digit    = digit_q;
    assign bus.minor    = minor_q;
    assign bus.major_d0 = major_q;
    assign bus.running  = (state_q != IDLE);
endmodule

// File: tb/tb_digit_pulse_gen.sv
// Self-checking bench for digit_pulse_gen: directed scenarios plus random control traffic
// compared every cycle against a behavioural model of the digit/minor timing.
module tb_digit_pulse_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    digit_pulse_gen_if #(.DIGITS(36), .MINOR_W(4)) bus ();

    digit_pulse_gen #(.DIGITS(36), .MINORS(16), .MINOR_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // behavioural model: running flag, position in the minor cycle, minor index
    bit m_run, m_one_shot, m_halt_req;
    int m_pos, m_minor;

    int cyc = 0;
    int maj_cnt = 0, maj_last = 0, maj_gap_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_update(input bit rn, input bit st, input bit sp, input bit stp);
        if (!rn) begin
            m_run = 0; m_one_shot = 0; m_halt_req = 0; m_pos = 0; m_minor = 0;
        end else if (!m_run) begin
            if (!stp && (st || sp)) begin
                m_run = 1;
                m_one_shot = !st;
                m_pos = 0;
            end
        end else if (m_pos == 35) begin
            m_pos = 0;
            m_minor = (m_minor + 1) % 16;
            if (m_one_shot || m_halt_req || stp) begin
                m_run = 0;
                m_halt_req = 0;
            end
        end else begin
            m_pos++;
            if (!m_one_shot && stp) m_halt_req = 1;
        end
    endtask

    task automatic compare_all();
        logic [63:0] ed;
        ed = m_run ? (64'd1 << m_pos) : 64'd0;
        check_val("d", {28'd0, bus.d}, ed);
        check_val("running", 64'(bus.running), 64'(m_run));
        check_val("digit", 64'(bus.digit), 64'(m_pos));
        check_val("minor", 64'(bus.minor), 64'(m_minor));
        check_val("taps", 64'({bus.d0, bus.d1, bus.d18, bus.d35, bus.major_d0}),
                  64'({ed[0], ed[1], ed[18], ed[35], m_run && m_pos == 0 && m_minor == 0}));
    endtask

    task automatic cycle(input bit rn, input bit st, input bit sp, input bit stp);
        rst_n = rn; bus.start = st; bus.step = sp; bus.stop = stp;
        @(posedge clk);
        model_update(rn, st, sp, stp);
        @(negedge clk);
        cyc++;
        compare_all();
        if (bus.major_d0) begin
            if (maj_cnt > 0 && (cyc - maj_last) != 576) maj_gap_bad++;
            maj_last = cyc;
            maj_cnt++;
        end
    endtask

    task automatic run_until(input int mn, input int p, input int budget);
        int n = 0;
        while (!(m_run && m_minor == mn && m_pos == p) && n < budget) begin
            cycle(1, 0, 0, 0);
            n++;
        end
        check_val("reach_point", 64'(m_run && m_minor == mn && m_pos == p), 64'd1);
    endtask

    initial begin
        int n;
        bus.start = 0; bus.stop = 0; bus.step = 0;
        m_run = 0; m_one_shot = 0; m_halt_req = 0; m_pos = 0; m_minor = 0;

        // reset held with start asserted
        repeat (3) cycle(0, 1, 0, 0);
        check_val("rst_running", 64'(bus.running), 64'd0);
        check_val("rst_d", {28'd0, bus.d}, 64'd0);

        // start, then 40 minor cycles of continuous running
        maj_cnt = 0; maj_gap_bad = 0;
        cycle(1, 1, 0, 0);
        check_val("first_d0", 64'(bus.d0), 64'd1);
        repeat (40 * 36 - 1) cycle(1, 0, 0, 0);
        check_val("major_cnt", 64'(maj_cnt), 64'd3);
        check_val("major_gap", 64'(maj_gap_bad), 64'd0);
        check_val("run40_minor", 64'(bus.minor), 64'd7);

        // stop pulse mid-cycle at minor 3, digit 10
        cycle(0, 0, 0, 0);
        cycle(1, 1, 0, 0);
        run_until(3, 10, 300);
        cycle(1, 0, 0, 1);
        n = 0;
        while (m_run && n < 40) begin cycle(1, 0, 0, 0); n++; end
        check_val("stop_halt_running", 64'(bus.running), 64'd0);
        check_val("stop_halt_minor", 64'(bus.minor), 64'd4);
        check_val("stop_halt_digit", 64'(bus.digit), 64'd0);
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        check_val("restart_d0", 64'(bus.d0), 64'd1);
        check_val("restart_minor", 64'(bus.minor), 64'd4);

        // stop on the d35 cycle, then start+stop together while idle
        run_until(4, 35, 60);
        cycle(1, 0, 0, 1);
        check_val("stop_d35_running", 64'(bus.running), 64'd0);
        check_val("stop_d35_minor", 64'(bus.minor), 64'd5);
        cycle(1, 1, 0, 1);
        check_val("start_stop_idle", 64'(bus.running), 64'd0);

        // reach idle at minor 15, then single step across the wrap
        cycle(1, 1, 0, 0);
        run_until(14, 35, 400);
        cycle(1, 0, 0, 1);
        check_val("pre_step_minor", 64'(bus.minor), 64'd15);
        cycle(1, 0, 1, 0);
        n = 0;
        for (int i = 0; i < 36; i++) begin
            if (bus.running) n++;
            cycle(1, i == 10, 0, 0);
        end
        check_val("step_pulses", 64'(n), 64'd36);
        check_val("step_end_running", 64'(bus.running), 64'd0);
        check_val("step_end_minor", 64'(bus.minor), 64'd0);

        // reset in the middle of a running minor cycle
        cycle(1, 1, 0, 0);
        run_until(0, 20, 60);
        cycle(0, 0, 0, 0);
        check_val("midrst_d", {28'd0, bus.d}, 64'd0);
        check_val("midrst_minor", 64'(bus.minor), 64'd0);
        cycle(1, 0, 0, 0);

        // random control traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 300) != 0, ($urandom % 20) == 0,
                  ($urandom % 25) == 0, ($urandom % 15) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
